// File: rtl/dp_latency_sched_pkg.sv
// Shared widths, default latencies and the in-flight operation record
// for the dual-port latency scheduler.
package dp_latency_sched_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int MEM_DEPTH   = 32;
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH);
    // Stored word width: data plus SECDED Hamming check bits (4 + overall parity)
    localparam int MEM_WIDTH   = DATA_WIDTH + 5;

    localparam int WR_LATENCYA = 10;
    localparam int RD_LATENCYA = 5;
    localparam int WR_LATENCYB = 7;
    localparam int RD_LATENCYB = 8;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  valid;
    } mem_op_t;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dp_latency_sched_port_sched.sv
// port_sched: one port's delay line, issue-slot reservation vector,
// ready logic and read-data return. Slot k of the line holds the op that
// drives the memory port k cycles from now, so slot 0 is the live issue.
module port_sched #(
    parameter int WR_LAT = dp_latency_sched_pkg::WR_LATENCYA,
    parameter int RD_LAT = dp_latency_sched_pkg::RD_LATENCYA
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_req_valid,
    input  logic                                        i_req_we,
    input  logic [dp_latency_sched_pkg::ADDR_WIDTH-1:0] i_req_addr,
    input  logic [dp_latency_sched_pkg::DATA_WIDTH-1:0] i_req_wdata,
    output logic                                        o_req_ready,
    output dp_latency_sched_pkg::mem_op_t               o_issue,
    input  logic [dp_latency_sched_pkg::DATA_WIDTH-1:0] i_mem_rdata,
    output logic                                        o_rd_valid,
    output logic [dp_latency_sched_pkg::DATA_WIDTH-1:0] o_rd_data
);
    import dp_latency_sched_pkg::*;

    localparam int DEPTH = lat_max(WR_LAT, RD_LAT);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_resv;
    mem_op_t          r_line [DEPTH];
    logic             r_rd_pend_p1;

    logic             w_busy;
    logic             w_accept;
    logic [IW-1:0]    w_idx;
    logic [DEPTH-1:0] w_claim;
    mem_op_t          w_new;

    // Slot check: before the edge, the slot an accept would land in after
    // the shift is still one position higher (L-1); it lands at L-2.
    always_comb begin
        w_busy       = i_req_we ? r_resv[WR_LAT-1] : r_resv[RD_LAT-1];
        w_idx        = i_req_we ? IW'(WR_LAT-2) : IW'(RD_LAT-2);
        w_accept     = i_req_valid & ~w_busy;
        w_claim      = '0;
        if (w_accept) begin
            w_claim[w_idx] = 1'b1;
        end
        w_new.we     = i_req_we;
        w_new.addr   = i_req_addr;
        w_new.wdata  = i_req_wdata;
        w_new.valid  = 1'b1;
    end

    assign o_req_ready = ~w_busy;

    // Reservation shift/claim and read-return strobe (control only is reset)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resv       <= '0;
            r_rd_pend_p1 <= 1'b0;
        end else begin
            r_resv       <= (r_resv >> 1) | w_claim;
            r_rd_pend_p1 <= r_resv[0] & ~r_line[0].we;
        end
    end

    // Delay-line payload shifts toward the issue slot; validity lives in r_resv
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DEPTH-1; k++) begin
            r_line[k] <= r_line[k+1];
        end
        if (w_accept) begin
            r_line[w_idx] <= w_new;
        end
    end

    // Live issue slot, with validity taken from the reservation vector
    always_comb begin
        o_issue       = r_line[0];
        o_issue.valid = r_resv[0];
    end

    // Memory read data is already registered; it is presented in the cycle after issue
    assign o_rd_valid = r_rd_pend_p1;
    assign o_rd_data  = r_rd_pend_p1 ? i_mem_rdata : '0;

endmodule

// File: rtl/dp_latency_sched.sv
// dp_latency_sched: per-port latency scheduler in front of a single-cycle
// dual-port memory. Holds the cross-port write-collision compare and the
// reset gating of all outputs.
// Build option: define COLLISION_CHECK_EN to suppress port B on a
// same-cycle same-address write from both ports and pulse o_collision_err.
module dp_latency_sched #(
    parameter int DATA_WIDTH  = dp_latency_sched_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = dp_latency_sched_pkg::ADDR_WIDTH,
    parameter int WR_LATENCYA = dp_latency_sched_pkg::WR_LATENCYA,
    parameter int RD_LATENCYA = dp_latency_sched_pkg::RD_LATENCYA,
    parameter int WR_LATENCYB = dp_latency_sched_pkg::WR_LATENCYB,
    parameter int RD_LATENCYB = dp_latency_sched_pkg::RD_LATENCYB
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid_a,
    output logic                  o_req_ready_a,
    input  logic                  i_req_we_a,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_a,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_a,
    output logic                  o_mem_en_a,
    output logic                  o_mem_we_a,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_a,
    output logic [DATA_WIDTH-1:0] o_mem_wdata_a,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata_a,
    output logic                  o_rd_valid_a,
    output logic [DATA_WIDTH-1:0] o_rd_data_a,
    input  logic                  i_req_valid_b,
    output logic                  o_req_ready_b,
    input  logic                  i_req_we_b,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_b,
    input  logic [DATA_WIDTH-1:0] i_req_wdata_b,
    output logic                  o_mem_en_b,
    output logic                  o_mem_we_b,
    output logic [ADDR_WIDTH-1:0] o_mem_addr_b,
    output logic [DATA_WIDTH-1:0] o_mem_wdata_b,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata_b,
    output logic                  o_rd_valid_b,
    output logic [DATA_WIDTH-1:0] o_rd_data_b,
    output logic                  o_collision_err
);
    import dp_latency_sched_pkg::*;

    mem_op_t                 w_issue_a;
    mem_op_t                 w_issue_b;
    logic                    w_ready_a;
    logic                    w_ready_b;
    logic                    w_rd_valid_a;
    logic                    w_rd_valid_b;
    logic [DATA_WIDTH-1:0]   w_rd_data_a;
    logic [DATA_WIDTH-1:0]   w_rd_data_b;
    logic                    w_col;

    port_sched #(.WR_LAT(WR_LATENCYA), .RD_LAT(RD_LATENCYA)) u_port_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid_a),
        .i_req_we    (i_req_we_a),
        .i_req_addr  (i_req_addr_a),
        .i_req_wdata (i_req_wdata_a),
        .o_req_ready (w_ready_a),
        .o_issue     (w_issue_a),
        .i_mem_rdata (i_mem_rdata_a),
        .o_rd_valid  (w_rd_valid_a),
        .o_rd_data   (w_rd_data_a)
    );

    port_sched #(.WR_LAT(WR_LATENCYB), .RD_LAT(RD_LATENCYB)) u_port_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid_b),
        .i_req_we    (i_req_we_b),
        .i_req_addr  (i_req_addr_b),
        .i_req_wdata (i_req_wdata_b),
        .o_req_ready (w_ready_b),
        .o_issue     (w_issue_b),
        .i_mem_rdata (i_mem_rdata_b),
        .o_rd_valid  (w_rd_valid_b),
        .o_rd_data   (w_rd_data_b)
    );

`ifdef COLLISION_CHECK_EN
    // Both ports writing the same word in the same cycle: A wins
    assign w_col = w_issue_a.valid & w_issue_a.we &
                   w_issue_b.valid & w_issue_b.we &
                   (w_issue_a.addr == w_issue_b.addr);
`else
    assign w_col = 1'b0;
`endif

    // Output gating: everything idles at zero while reset is held
    always_comb begin
        o_req_ready_a   = ~i_rst & w_ready_a;
        o_req_ready_b   = ~i_rst & w_ready_b;

        o_mem_en_a      = ~i_rst & w_issue_a.valid;
        o_mem_we_a      = ~i_rst & w_issue_a.valid & w_issue_a.we;
        o_mem_addr_a    = i_rst ? '0 : w_issue_a.addr;
        o_mem_wdata_a   = i_rst ? '0 : w_issue_a.wdata;

        o_mem_en_b      = ~i_rst & w_issue_b.valid & ~w_col;
        o_mem_we_b      = ~i_rst & w_issue_b.valid & w_issue_b.we & ~w_col;
        o_mem_addr_b    = i_rst ? '0 : w_issue_b.addr;
        o_mem_wdata_b   = i_rst ? '0 : w_issue_b.wdata;

        o_rd_valid_a    = ~i_rst & w_rd_valid_a;
        o_rd_data_a     = i_rst ? '0 : w_rd_data_a;
        o_rd_valid_b    = ~i_rst & w_rd_valid_b;
        o_rd_data_b     = i_rst ? '0 : w_rd_data_b;

        o_collision_err = ~i_rst & w_col;
    end

endmodule

// File: tb/tb_dp_latency_sched.sv
// Directed bench for dp_latency_sched with a behavioural dual-port memory
// (registered read data, read-before-write). Cycle c of a scenario is the
// cycle in which stimulus is presented; outputs are sampled on the falling edge.
module tb_dp_latency_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       va, wea, vb, web;
    logic [4:0] addra, addrb;
    logic [7:0] wda, wdb;
    logic       ready_a, ready_b;
    logic       en_a, we_a, en_b, we_b;
    logic [4:0] maddr_a, maddr_b;
    logic [7:0] mwd_a, mwd_b;
    logic [7:0] rdata_a, rdata_b;
    logic       rdv_a, rdv_b;
    logic [7:0] rdd_a, rdd_b;
    logic       col;

    logic       mem_init;
    logic [7:0] tb_mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_latency_sched dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid_a  (va),
        .o_req_ready_a  (ready_a),
        .i_req_we_a     (wea),
        .i_req_addr_a   (addra),
        .i_req_wdata_a  (wda),
        .o_mem_en_a     (en_a),
        .o_mem_we_a     (we_a),
        .o_mem_addr_a   (maddr_a),
        .o_mem_wdata_a  (mwd_a),
        .i_mem_rdata_a  (rdata_a),
        .o_rd_valid_a   (rdv_a),
        .o_rd_data_a    (rdd_a),
        .i_req_valid_b  (vb),
        .o_req_ready_b  (ready_b),
        .i_req_we_b     (web),
        .i_req_addr_b   (addrb),
        .i_req_wdata_b  (wdb),
        .o_mem_en_b     (en_b),
        .o_mem_we_b     (we_b),
        .o_mem_addr_b   (maddr_b),
        .o_mem_wdata_b  (mwd_b),
        .i_mem_rdata_b  (rdata_b),
        .o_rd_valid_b   (rdv_b),
        .o_rd_data_b    (rdd_b),
        .o_collision_err(col)
    );

    // Memory model: pattern fill during init, then both ports; reads see old data
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (en_a && we_a) tb_mem[maddr_a] <= mwd_a;
            if (en_b && we_b) tb_mem[maddr_b] <= mwd_b;
        end
        if (en_a && !we_a) rdata_a <= tb_mem[maddr_a];
        if (en_b && !we_b) rdata_b <= tb_mem[maddr_b];
    end

    task automatic clr();
        va = 0; wea = 0; addra = 0; wda = 0;
        vb = 0; web = 0; addrb = 0; wdb = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1; mem_init = 1; clr();
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        checks++;
        if ({ready_a, ready_b, en_a, en_b, we_a, we_b, rdv_a, rdv_b, col} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000000",
                     {ready_a, ready_b, en_a, en_b, we_a, we_b, rdv_a, rdv_b, col});
        end
        checks++;
        if ({maddr_a, maddr_b, mwd_a, mwd_b, rdd_a, rdd_b} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {maddr_a, maddr_b, mwd_a, mwd_b, rdd_a, rdd_b});
        end
        step();
        rst = 0; mem_init = 0;
        @(negedge clk);
        checks++;
        if ({ready_a, ready_b} !== 2'b11) begin
            errors++;
            $display("FAIL first_ready got %b exp 11", {ready_a, ready_b});
        end
        step();
    endtask

    task automatic test_single();
        for (int c = 0; c < 27; c++) begin
            clr();
            if (c == 0)  begin va = 1; wea = 1; addra = 5'd3; wda = 8'hA5; end
            if (c == 20) begin va = 1; wea = 0; addra = 5'd3; end
            @(negedge clk);
            if (c == 0 || c == 20) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    errors++; $display("FAIL single_ready c=%0d got %b exp 1", c, ready_a);
                end
            end
            checks++;
            if (en_a !== (c == 9 || c == 24)) begin
                errors++; $display("FAIL single_en c=%0d got %b exp %b", c, en_a, (c == 9 || c == 24));
            end
            if (c == 9) begin
                checks++;
                if ({we_a, maddr_a, mwd_a} !== {1'b1, 5'd3, 8'hA5}) begin
                    errors++; $display("FAIL single_wr got %h exp %h", {we_a, maddr_a, mwd_a}, {1'b1, 5'd3, 8'hA5});
                end
            end
            if (c == 24) begin
                checks++;
                if ({we_a, maddr_a} !== {1'b0, 5'd3}) begin
                    errors++; $display("FAIL single_rd_issue got %h exp %h", {we_a, maddr_a}, {1'b0, 5'd3});
                end
            end
            checks++;
            if (rdv_a !== (c == 25)) begin
                errors++; $display("FAIL single_rdv c=%0d got %b exp %b", c, rdv_a, (c == 25));
            end
            if (c == 25) begin
                checks++;
                if (rdd_a !== 8'hA5) begin
                    errors++; $display("FAIL single_rdata got %h exp a5", rdd_a);
                end
            end
            step();
        end
        clr();
    endtask

    task automatic test_slot_conflict();
        for (int c = 0; c < 13; c++) begin
            clr();
            if (c == 0)           begin va = 1; wea = 1; addra = 5'd1; wda = 8'h5C; end
            if (c == 5 || c == 6) begin va = 1; wea = 0; addra = 5'd1; end
            @(negedge clk);
            if (c == 5 || c == 6) begin
                checks++;
                if (ready_a !== (c == 6)) begin
                    errors++; $display("FAIL slot_ready c=%0d got %b exp %b", c, ready_a, (c == 6));
                end
            end
            checks++;
            if ({en_a, we_a} !== {(c == 9 || c == 10), (c == 9)}) begin
                errors++; $display("FAIL slot_issue c=%0d got %b exp %b", c, {en_a, we_a}, {(c == 9 || c == 10), (c == 9)});
            end
            checks++;
            if (rdv_a !== (c == 11)) begin
                errors++; $display("FAIL slot_rdv c=%0d got %b exp %b", c, rdv_a, (c == 11));
            end
            if (c == 11) begin
                checks++;
                if (rdd_a !== 8'h5C) begin
                    errors++; $display("FAIL slot_rdata got %h exp 5c", rdd_a);
                end
            end
            step();
        end
        clr();
    endtask

    task automatic test_overtake();
        for (int c = 0; c < 11; c++) begin
            clr();
            if (c == 0) begin vb = 1; web = 1; addrb = 5'd7; wdb = 8'h11; end
            if (c == 1) begin vb = 1; web = 0; addrb = 5'd7; end
            @(negedge clk);
            if (c <= 1) begin
                checks++;
                if (ready_b !== 1'b1) begin
                    errors++; $display("FAIL ovt_ready c=%0d got %b exp 1", c, ready_b);
                end
            end
            checks++;
            if ({en_b, we_b} !== {(c == 6 || c == 8), (c == 6)}) begin
                errors++; $display("FAIL ovt_issue c=%0d got %b exp %b", c, {en_b, we_b}, {(c == 6 || c == 8), (c == 6)});
            end
            checks++;
            if (rdv_b !== (c == 9)) begin
                errors++; $display("FAIL ovt_rdv c=%0d got %b exp %b", c, rdv_b, (c == 9));
            end
            if (c == 9) begin
                checks++;
                if (rdd_b !== 8'h11) begin
                    errors++; $display("FAIL ovt_rdata got %h exp 11", rdd_b);
                end
            end
            step();
        end
        clr();
    endtask

    task automatic test_collision();
        logic exp_en_b, exp_col;
        for (int c = 0; c < 19; c++) begin
            clr();
            if (c == 0)  begin va = 1; wea = 1; addra = 5'd4; wda = 8'h22; end
            if (c == 3)  begin vb = 1; web = 1; addrb = 5'd4; wdb = 8'h33; end
            if (c == 12) begin va = 1; wea = 0; addra = 5'd4; end
            @(negedge clk);
`ifdef COLLISION_CHECK_EN
            exp_en_b = 1'b0;
            exp_col  = (c == 9);
`else
            exp_en_b = (c == 9);
            exp_col  = 1'b0;
`endif
            checks++;
            if ({en_a, en_b, col} !== {(c == 9 || c == 16), exp_en_b, exp_col}) begin
                errors++; $display("FAIL col_issue c=%0d got %b exp %b", c, {en_a, en_b, col}, {(c == 9 || c == 16), exp_en_b, exp_col});
            end
`ifdef COLLISION_CHECK_EN
            if (c == 17) begin
                checks++;
                if ({rdv_a, rdd_a} !== {1'b1, 8'h22}) begin
                    errors++; $display("FAIL col_readback got %h exp 122", {rdv_a, rdd_a});
                end
            end
`endif
            step();
        end
        clr();
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 14; c++) begin
            clr();
            rst = (c == 4);
            if (c <= 2) begin va = 1; wea = 1; addra = 5'(10 + c); wda = 8'(8'hC0 + c); end
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({ready_a, en_a, we_a, maddr_a, mwd_a, rdv_a, rdd_a, col} !== '0) begin
                    errors++; $display("FAIL mid_rst_out got %h exp 0", {ready_a, en_a, we_a, maddr_a, mwd_a, rdv_a, rdd_a, col});
                end
            end
            if (c == 5) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    errors++; $display("FAIL mid_ready_after got %b exp 1", ready_a);
                end
            end
            if (c >= 5) begin
                checks++;
                if (en_a !== 1'b0) begin
                    errors++; $display("FAIL mid_dropped c=%0d got %b exp 0", c, en_a);
                end
            end
            step();
        end
        rst = 0;
        clr();
    endtask

    task automatic test_back_to_back();
        int   pulses;
        logic [4:0] a;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            clr();
            if (c < 20) begin va = 1; wea = 0; addra = 5'((c + 13) % 32); end
            @(negedge clk);
            if (c < 20) begin
                checks++;
                if (ready_a !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, ready_a);
                end
            end
            checks++;
            if (rdv_a !== (c >= 5 && c <= 24)) begin
                errors++; $display("FAIL b2b_rdv c=%0d got %b exp %b", c, rdv_a, (c >= 5 && c <= 24));
            end
            if (rdv_a === 1'b1) pulses++;
            if (c >= 5 && c <= 24) begin
                a = 5'((c - 5 + 13) % 32);
                checks++;
                if (rdd_a !== 8'(a * 7 + 3)) begin
                    errors++; $display("FAIL b2b_rdata c=%0d got %h exp %h", c, rdd_a, 8'(a * 7 + 3));
                end
            end
            step();
        end
        checks++;
        if (pulses != 20) begin
            errors++; $display("FAIL b2b_count got %0d exp 20", pulses);
        end
        clr();
    endtask

    initial begin
        rst = 1; mem_init = 1;
        clr();
        test_reset();
        test_single();
        idle(12);
        test_slot_conflict();
        idle(12);
        test_overtake();
        idle(12);
        test_collision();
        idle(12);
        test_reset_midflight();
        idle(12);
        test_back_to_back();
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
